axis_uart_transmitter: RTL and testbench
========================================

Name: axis_uart_transmitter

Overview:
- AXI4-Stream-slave to UART serial transmitter.
- Accepts one DATA_WIDTH-bit word per tvalid/tready handshake and serialises it as a standard 8N1-style frame: start bit, data bits LSB first, one stop bit.
- Sits between an on-chip stream source and the external TX pin.
- Baud timing is derived from the system clock by an integer divider.

Parameters:
- CLK_FREQ_HZ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 9_600, serial bit rate in bits/s.
- DATA_WIDTH, 8, number of data bits per frame (1..16).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tdata  input  DATA_WIDTH  stream payload, sampled on handshake.
- tvalid  input  1  source has valid tdata.
- tready  output  1  block can accept a word (high only in IDLE).
- out  output  1  UART TX line; idles high.

Behaviour:
- CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer division, truncating (13020 at defaults).
  - Elaboration error if the result is < 2.
  - Bit counter width is clog2(CLKS_PER_BIT).
- Reset (rst_n low, asynchronous): state = IDLE, out = 1, tready = 1, counters and shift register cleared. This applies mid-frame: the line returns high immediately and the partial frame is abandoned.
- States:
  - IDLE: out = 1, tready = 1. A handshake (tvalid & tready at a rising edge) latches tdata into the shift register and moves to START. tready drops and out goes 0 on that same edge.
  - START: out = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: out = shift register bit 0 for CLKS_PER_BIT cycles, then shift right. Repeats for DATA_WIDTH bits (LSB first), then STOP.
  - STOP: out = 1 for CLKS_PER_BIT cycles, then IDLE with tready = 1.
- Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles from handshake edge to tready re-assertion.
- out and tready are registered; there is no combinational path from tvalid or tdata.
- tdata changes after the handshake have no effect on the frame in flight.
- tvalid while tready is low is ignored; no buffering.
- If tvalid is held high continuously, the next word is accepted on the first edge with tready = 1. The minimum inter-frame line-high time is therefore CLKS_PER_BIT + 1 cycles (stop bit plus one IDLE cycle).
- tvalid may deassert without a handshake; no AXI-Stream stability requirement is enforced on the source.

Test Plan:
- Reset: hold rst_n low, toggle tvalid -> out = 1, tready = 1 throughout. Release rst_n -> still idle, no frame.
- Single byte, CLK_FREQ_HZ=1000, BAUD_RATE=100 (10 clk/bit):
  - Stimulus: one-cycle tvalid with tdata=8'hC5 while tready=1.
  - out sequence per 10-cycle bit: 0 | 1,0,1,0,0,0,1,1 | 1.
  - tready low for exactly 100 cycles, then high.
- Defaults (125 MHz, 9600 baud), tdata=8'hC5 pulsed 1 cycle after reset -> start bit low for 13020 cycles; full frame 130200 cycles.
- Back-to-back: tvalid held high with tdata=8'h00 then 8'hFF -> second start bit begins exactly 11 cycles after the first stop bit begins (10-clk/bit config). tdata changed mid-frame does not corrupt the first frame.
- Busy ignore: tvalid pulses with 8'h55 during a frame -> not accepted, no extra frame, line idle after the first frame.
- Mid-frame reset: assert rst_n low during the DATA state -> out = 1 and tready = 1 asynchronously. After release, a new 8'hA3 frame transmits cleanly.

Source files
------------

// File: rtl/axis_uart_transmitter.sv
// axis_uart_transmitter
//   AXI4-Stream slave to UART transmitter. Each accepted word goes out as one
//   frame: a start bit (0), DATA_WIDTH data bits LSB first, and a stop bit (1).
//   Bit timing comes from an integer divide of the system clock.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   tdata   in   stream payload, captured on tvalid & tready
//   tvalid  in   source has a word
//   tready  out  high only while idle (registered)
//   out     out  UART TX line, idles high (registered)
module axis_uart_transmitter #(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned BAUD_RATE   = 9_600,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  output logic                  tready,
  output logic                  out
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_divider
    $error("axis_uart_transmitter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end

  if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
    $error("axis_uart_transmitter: DATA_WIDTH must be in 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      clk_cnt_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  out_q;
  logic                  tready_q;
  logic                  bit_end;

  // Shifted-out view of the register; its bit 0 is the next data bit on the line.
  always_comb begin
    shift_d = shift_q >> 1;
    bit_end = (clk_cnt_q == CNT_LAST);
  end

  // Outputs are registered and loaded one edge ahead of the state they belong
  // to, so the line changes on the same edge as the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      out_q     <= 1'b1;
      tready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (tvalid && tready_q) begin
            shift_q  <= tdata;
            state_q  <= S_START;
            tready_q <= 1'b0;
            out_q    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
            out_q     <= shift_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_d;
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= S_STOP;
              out_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              out_q     <= shift_d[0];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
            tready_q  <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          out_q    <= 1'b1;
          tready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign tready = tready_q;

endmodule

// File: tb/tb_axis_uart_transmitter.sv
module tb_axis_uart_transmitter;

  localparam int unsigned CPB     = 10;     // 1000 Hz / 100 baud
  localparam int unsigned DEF_CPB = 13020;  // 125 MHz / 9600 baud
  localparam int unsigned FRAME   = 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-divider instance used for most scenarios
  logic       rst_n;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tx_line;

  // Default-parameter instance used for the real-baud timing check
  logic       d_rst_n;
  logic [7:0] d_tdata;
  logic       d_tvalid;
  logic       d_tready;
  logic       d_tx_line;

  int n_checks = 0;
  int n_fail   = 0;

  axis_uart_transmitter #(
    .CLK_FREQ_HZ(1000),
    .BAUD_RATE  (100),
    .DATA_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tdata (tdata),
    .tvalid(tvalid),
    .tready(tready),
    .out   (tx_line)
  );

  axis_uart_transmitter dut_def (
    .clk   (clk),
    .rst_n (d_rst_n),
    .tdata (d_tdata),
    .tvalid(d_tvalid),
    .tready(d_tready),
    .out   (d_tx_line)
  );

  // Reference line value k cycles after the handshake edge (k = 0 is the
  // cycle right after that edge).
  function automatic logic exp_line(input logic [7:0] d, input int unsigned k);
    int unsigned b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    tdata  = 8'h5A;
    tvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 tvalid = ~tvalid;
      @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || tready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: out=%b tready=%b expected out=1 tready=1", i, tx_line, tready);
      end
    end
    @(posedge clk); #1 tvalid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || tready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: out=%b tready=%b expected out=1 tready=1", i, tx_line, tready);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_bits [10];
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    @(posedge clk); #1 tdata = 8'hC5; tvalid = 1'b1;
    @(posedge clk); #1 tvalid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== exp_bits[k / CPB] || tready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_C5 k=%0d: out=%b tready=%b expected out=%b tready=0", k, tx_line, tready, exp_bits[k / CPB]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx_line !== 1'b1 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_C5_end: out=%b tready=%b expected out=1 tready=1", tx_line, tready);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 tdata = 8'h00; tvalid = 1'b1;
    @(posedge clk); #1 tdata = 8'hFF;   // handshake just took 8'h00
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== exp_line(8'h00, k) || tready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d: out=%b tready=%b expected out=%b tready=0", k, tx_line, tready, exp_line(8'h00, k));
      end
    end
    // One idle cycle between frames: stop began at k=90, next start at k=101
    @(negedge clk);
    n_checks++;
    if (tx_line !== 1'b1 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: out=%b tready=%b expected out=1 tready=1", tx_line, tready);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) tvalid = 1'b0;
      n_checks++;
      if (tx_line !== exp_line(8'hFF, k) || tready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_second k=%0d: out=%b tready=%b expected out=%b tready=0", k, tx_line, tready, exp_line(8'hFF, k));
      end
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || tready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_idle cyc %0d: out=%b tready=%b expected out=1 tready=1", i, tx_line, tready);
      end
    end
  endtask

  task automatic test_busy_ignore();
    @(posedge clk); #1 tdata = 8'h3C; tvalid = 1'b1;
    @(posedge clk); #1 tvalid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== exp_line(8'h3C, k) || tready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_frame k=%0d: out=%b tready=%b expected out=%b tready=0", k, tx_line, tready, exp_line(8'h3C, k));
      end
      if (k == 30 || k == 60 || k == 95) begin
        tdata  = 8'h55;
        tvalid = 1'b1;
      end else begin
        tvalid = 1'b0;
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || tready !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_idle cyc %0d: out=%b tready=%b expected out=1 tready=1", i, tx_line, tready);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 tdata = 8'hA3; tvalid = 1'b1;
    @(posedge clk); #1 tvalid = 1'b0;
    for (int k = 0; k < 35; k++) @(negedge clk);
    // k=34 sits in data bit 3 of 8'hA3, which is 0
    n_checks++;
    if (tx_line !== 1'b0 || tready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: out=%b tready=%b expected out=0 tready=0", tx_line, tready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_line !== 1'b1 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: out=%b tready=%b expected out=1 tready=1", tx_line, tready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1 || tready !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_idle cyc %0d: out=%b tready=%b expected out=1 tready=1", i, tx_line, tready);
      end
    end
    @(posedge clk); #1 tdata = 8'hA3; tvalid = 1'b1;
    @(posedge clk); #1 tvalid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_line !== exp_line(8'hA3, k) || tready !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_frame k=%0d: out=%b tready=%b expected out=%b tready=0", k, tx_line, tready, exp_line(8'hA3, k));
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx_line !== 1'b1 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_end: out=%b tready=%b expected out=1 tready=1", tx_line, tready);
    end
  endtask

  // Default divider: the start bit must last exactly 13020 cycles, followed by
  // data bit 0 of 8'hC5 (a 1). The rest of the 130200-cycle frame is cut short
  // by reset to keep the run time down.
  task automatic test_defaults();
    int unsigned low_cycles;
    int unsigned bad_ready;
    low_cycles = 0;
    bad_ready  = 0;
    @(posedge clk); #1 d_rst_n = 1'b1;
    @(posedge clk); #1 d_tdata = 8'hC5; d_tvalid = 1'b1;
    @(posedge clk); #1 d_tvalid = 1'b0;
    for (int k = 0; k < DEF_CPB; k++) begin
      @(negedge clk);
      if (d_tx_line === 1'b0) low_cycles++;
      if (d_tready !== 1'b0) bad_ready++;
    end
    n_checks++;
    if (low_cycles != DEF_CPB) begin
      n_fail++;
      $display("FAIL defaults_start_len: low cycles=%0d expected %0d", low_cycles, DEF_CPB);
    end
    n_checks++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL defaults_tready: tready high in %0d start cycles expected 0", bad_ready);
    end
    @(negedge clk);
    n_checks++;
    if (d_tx_line !== 1'b1 || d_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL defaults_bit0: out=%b tready=%b expected out=1 tready=0", d_tx_line, d_tready);
    end
    d_rst_n = 1'b0;
    #1;
    n_checks++;
    if (d_tx_line !== 1'b1 || d_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL defaults_reset: out=%b tready=%b expected out=1 tready=1", d_tx_line, d_tready);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tdata    = '0;
    tvalid   = 1'b0;
    d_rst_n  = 1'b0;
    d_tdata  = '0;
    d_tvalid = 1'b0;

    test_reset();
    test_single_byte();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_defaults();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
